io_port_ctrl: RTL and testbench

// - I/O responder for the single-cycle CPU: services CPU I/O reads (data into the inm mux I/O input) and I/O writes (data from rd1).
// - Buffers one byte per input port from external producers (valid/ready handshake).
// - Drives registered output ports toward external consumers (valid/ack handshake).
// - Read data is combinational so the CPU consumes it in the same cycle. All state updates occur on the clk rising edge.

---
 rtl/io_port_ctrl_pkg.sv | 6 +
 rtl/io_in_slot.sv | 27 ++
 rtl/io_port_ctrl.sv | 85 ++++++++
 tb/tb_io_port_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/io_port_ctrl_pkg.sv
// io_port_ctrl_pkg: address map constants shared by the I/O responder
package io_port_ctrl_pkg;
    localparam int IO_ADDR_W = 3;
    localparam logic [IO_ADDR_W-1:0] IO_ADDR_STATUS = 3'd4;
    localparam logic [IO_ADDR_W-1:0] IO_ADDR_OVR = 3'd5;
endpackage

// File: rtl/io_in_slot.sv
// io_in_slot: one-byte input buffer, captures when empty, read-to-clear
module io_in_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    input  logic             clr,
    output logic             ready,
    output logic [WIDTH-1:0] q
);
    logic full;
    assign ready = ~full;
    // capture only when empty; a clear on the same edge as new data leaves a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            q <= '0;
        end else if (!full && valid) begin
            full <= 1'b1;
            q <= data;
        end else if (full && clr) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: CPU I/O responder with buffered input slots and handshaked output ports
module io_port_ctrl
    import io_port_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN = 4,
    parameter int N_OUT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   re_io,
    input  logic                   we_io,
    input  logic [IO_ADDR_W-1:0]   addr,
    input  logic [WIDTH-1:0]       wd_io,
    output logic [WIDTH-1:0]       rd_io,
    input  logic [N_IN*WIDTH-1:0]  in_data,
    input  logic [N_IN-1:0]        in_valid,
    output logic [N_IN-1:0]        in_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ack
);
    logic [3:0][WIDTH-1:0] in_q4;
    logic [3:0] full4, ov4, ovr4;
    logic ovr_clr;
    assign ovr_clr = re_io && addr == IO_ADDR_OVR;
    for (genvar i = 0; i < 4; i++) begin : g_in
        if (i < N_IN) begin : g_slot
            logic rdy;
            io_in_slot #(.WIDTH(WIDTH)) u_slot (
                .clk(clk),
                .reset(reset),
                .valid(in_valid[i]),
                .data(in_data[i*WIDTH +: WIDTH]),
                .clr(re_io && addr == IO_ADDR_W'(i)),
                .ready(rdy),
                .q(in_q4[i])
            );
            assign in_ready[i] = rdy;
            assign full4[i] = ~rdy;
        end else begin : g_none
            assign in_q4[i] = '0;
            assign full4[i] = 1'b0;
        end
    end
    for (genvar i = 0; i < 4; i++) begin : g_out
        if (i < N_OUT) begin : g_port
            logic [WIDTH-1:0] q;
            logic v, o, wr;
            assign wr = we_io && addr == IO_ADDR_W'(i);
            // accept a write when idle or when the pending byte is acked this cycle
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q <= '0;
                    v <= 1'b0;
                end else if (wr && (!v || out_ack[i])) begin
                    q <= wd_io;
                    v <= 1'b1;
                end else if (v && out_ack[i]) begin
                    v <= 1'b0;
                end
            end
            // sticky overrun on a dropped write; a new overrun beats a clearing read
            always_ff @(posedge clk or posedge reset) begin
                if (reset) o <= 1'b0;
                else if (wr && v && !out_ack[i]) o <= 1'b1;
                else if (ovr_clr) o <= 1'b0;
            end
            assign out_data[i*WIDTH +: WIDTH] = q;
            assign out_valid[i] = v;
            assign ov4[i] = v;
            assign ovr4[i] = o;
        end else begin : g_none
            assign ov4[i] = 1'b0;
            assign ovr4[i] = 1'b0;
        end
    end
    // combinational read mux so the CPU consumes data in the same cycle
    always_comb begin
        rd_io = !re_io ? '0 :
                !addr[2] ? in_q4[addr[1:0]] :
                addr == IO_ADDR_STATUS ? WIDTH'({ov4, full4}) :
                addr == IO_ADDR_OVR ? WIDTH'({4'b0, ovr4}) : '0;
    end
endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed self-checking bench for io_port_ctrl
module tb_io_port_ctrl;
    logic clk = 1'b0;
    logic reset, re_io, we_io;
    logic [2:0] addr;
    logic [7:0] wd_io, rd_io;
    logic [31:0] in_data, out_data;
    logic [3:0] in_valid, in_ready, out_valid, out_ack;
    int checks = 0;
    int errors = 0;

    io_port_ctrl dut (
        .clk(clk), .reset(reset), .re_io(re_io), .we_io(we_io), .addr(addr),
        .wd_io(wd_io), .rd_io(rd_io), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
        re_io = 1'b1;
        addr = a;
        #1;
        chk(tag, 32'(rd_io), 32'(exp));
    endtask

    initial begin
        reset = 1'b1; re_io = 0; we_io = 0; addr = 0; wd_io = 0;
        in_data = 0; in_valid = 0; out_ack = 0;
        step();
        step();
        reset = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'hF);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        rd(3'd4, 8'h00, "reset_status");
        re_io = 0;
        #1 chk("rd_idle_zero", 32'(rd_io), 32'h0);
        // input capture on slot 2
        in_valid[2] = 1'b1; in_data[23:16] = 8'hA5;
        step();
        in_valid = 0;
        chk("cap_in_ready", 32'(in_ready), 32'hB);
        rd(3'd4, 8'h04, "cap_status");
        rd(3'd2, 8'hA5, "cap_read");
        step();
        re_io = 0;
        chk("cap_cleared", 32'(in_ready), 32'hF);
        // read/valid collision on slot 0
        in_valid[0] = 1'b1; in_data[7:0] = 8'h11;
        step();
        in_data[7:0] = 8'h22;
        chk("col_full", 32'(in_ready[0]), 32'h0);
        rd(3'd0, 8'h11, "col_read_old");
        step();
        re_io = 0;
        chk("col_bubble", 32'(in_ready[0]), 32'h1);
        step();
        in_valid = 0;
        chk("col_captured", 32'(in_ready[0]), 32'h0);
        rd(3'd0, 8'h22, "col_read_new");
        step();
        re_io = 0;
        // output write and ack on port 1
        we_io = 1; addr = 3'd1; wd_io = 8'h3C;
        step();
        we_io = 0;
        chk("out_valid1", 32'(out_valid), 32'h2);
        chk("out_data1", 32'(out_data[15:8]), 32'h3C);
        out_ack[1] = 1'b1;
        step();
        out_ack = 0;
        chk("out_acked", 32'(out_valid), 32'h0);
        chk("out_data_hold", 32'(out_data[15:8]), 32'h3C);
        // overrun on port 3
        we_io = 1; addr = 3'd3; wd_io = 8'h77;
        step();
        wd_io = 8'h88;
        step();
        we_io = 0;
        chk("ovr_data_kept", 32'(out_data[31:24]), 32'h77);
        rd(3'd4, 8'h80, "ovr_status");
        rd(3'd5, 8'h08, "ovr_flag");
        step();
        rd(3'd5, 8'h00, "ovr_cleared");
        re_io = 0;
        // back-to-back on port 0
        we_io = 1; addr = 3'd0; wd_io = 8'h44;
        step();
        wd_io = 8'h55; out_ack[0] = 1'b1;
        step();
        we_io = 0; out_ack = 0;
        chk("b2b_data", 32'(out_data[7:0]), 32'h55);
        chk("b2b_valid", 32'(out_valid), 32'h9);
        rd(3'd5, 8'h00, "b2b_no_ovr");
        re_io = 0;
        // ack while idle and writes to status are ignored
        out_ack[2] = 1'b1; we_io = 1; addr = 3'd4; wd_io = 8'hFF;
        step();
        out_ack = 0; we_io = 0;
        chk("idle_ack", 32'(out_valid), 32'h9);
        rd(3'd4, 8'h90, "status_after_wr");
        rd(3'd6, 8'h00, "addr6_zero");
        // stale read of an empty slot has no side effect
        rd(3'd2, 8'hA5, "stale_read");
        step();
        re_io = 0;
        chk("stale_no_effect", 32'(in_ready), 32'hF);
        // asynchronous reset mid-cycle with pending state
        in_valid[1] = 1'b1; in_data[15:8] = 8'h5A;
        step();
        in_valid = 0;
        chk("pre_reset_ready", 32'(in_ready), 32'hD);
        #2 reset = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'hF);
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_out_data", out_data, 32'h0);
        rd(3'd4, 8'h00, "arst_status");
        reset = 1'b0;
        re_io = 0;
        step();
        rd(3'd1, 8'h00, "arst_discarded");
        re_io = 0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
